led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
- Parametrised LED pattern generator for CertusPro-NX boards, successor to the fixed 4-LED blinker.
- Supports NUM_LEDS outputs, runtime mode selection, auto-cycling through modes, a speed prescale and pause.
- Optional PWM brightness control.
- Sits at top level, driving board LEDs directly from the 50 MHz board clock.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- STEP_HZ, 4: base pattern step rate in Hz at speed=0.
- NUM_LEDS, 8: LED count. Legal range is 2..16.
- PWM_BITS, 8: brightness resolution. Used only with LED_PWM_EN.

Ports:
- clk_50mhz  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_sel  in  3  requested mode, 0..4. Values 5..7 are illegal.
- mode_load  in  1  one-cycle pulse; loads mode_sel.
- auto_cycle  in  1  1 = advance to the next mode at the end of each pattern.
- speed  in  2  step period multiplier of 2^speed (x1, x2, x4, x8).
- pause  in  1  1 = freeze step progress.
- brightness  in  PWM_BITS  duty control. Present only with LED_PWM_EN.
- led  out  NUM_LEDS  registered LED drive.
- mode_cur  out  3  active mode.
- step_tick  out  1  one-cycle pulse on each step advance.
- cycle_done  out  1  one-cycle pulse when the last step of a pattern is left.

Behaviour:
- Reset values: led=0, mode_cur=0, step index s=0, divider=0, step_tick=0, cycle_done=0.
- Divider:
  - STEP_DIV = CLK_FREQ/STEP_HZ.
  - Counts 0..(STEP_DIV<<speed)-1 while pause=0, then wraps.
  - step_tick=1 for one cycle at the wrap.
  - A speed change takes effect at the next compare. If the count already exceeds the new limit, it wraps immediately.
- Pause:
  - Holds the divider and s.
  - step_tick=0 while paused.
  - led holds its value (PWM gating still runs).
- Pattern length L(mode):
  - mode 0 = 2^NUM_LEDS.
  - mode 1 = 2*NUM_LEDS-2.
  - mode 2 = 2*NUM_LEDS.
  - mode 3 = 8.
  - mode 4 = 8.
- Pattern P(mode,s):
  - mode 0 binary: P = s.
  - mode 1 bounce: single bit at position s for s<NUM_LEDS; position 2*NUM_LEDS-2-s otherwise.
  - mode 2 fill/empty: for s<=NUM_LEDS, the low s bits are set; for s>NUM_LEDS, P = all-ones << (s-NUM_LEDS).
  - mode 3 alternate: even s gives ...0101, odd s gives ...1010.
  - mode 4 blink: even s gives all 0, odd s gives all 1.
- Step advance on step_tick:
  - If s<L-1: s <= s+1.
  - Else: s <= 0 and cycle_done=1 in the same cycle as step_tick.
  - If auto_cycle=1 at that point, mode_cur advances 0→1→2→3→4→0.
- led <= P(mode_cur,s) every cycle, giving one cycle of latency from an s or mode change.
- mode_load:
  - mode_sel 0..4: mode_cur <= mode_sel, s <= 0, divider <= 0 on the next edge.
  - mode_sel 5..7: the load is ignored and the state is unchanged.
  - The load is accepted while paused.
  - mode_load wins over a coincident step_tick: no cycle_done and no auto advance on that cycle.
- Wrap-around:
  - Mode 0 at s = 2^NUM_LEDS-1 wraps to 0.
  - s width is max(NUM_LEDS, 5) bits, with no overflow.
- Reset mid-pattern: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: LED_PWM_EN.
- When defined:
  - Adds the brightness port and a free-running PWM_BITS counter pc.
  - Output is led = P & {NUM_LEDS{pc < brightness}}, registered.
  - brightness=0 gives all LEDs off.
  - brightness all-ones forces full-on (no PWM gating).
- When undefined:
  - The brightness port and counter are absent.
  - led = P (100% duty).

Test Plan:
- Sim setup for all cases: CLK_FREQ=40, STEP_HZ=4 (STEP_DIV=10), NUM_LEDS=4.
- Reset, then speed=0, mode 0 → step_tick every 10 cycles. led sequence 1,2,…,15,0. cycle_done coincides with the tick leaving s=15.
- Load mode 1, auto_cycle=0 → led 0001,0010,0100,1000,0100,0010, then repeats. cycle_done every 6 ticks; mode_cur stays 1.
- Load mode 2, auto_cycle=1 → led 0000,0001,0011,0111,1111,1110,1100,1000. Then mode_cur=3 and led alternates 0101/1010; after 8 steps mode_cur=4.
- speed=2 → ticks every 40 cycles. pause=1 for 100 cycles → no tick and led stable; the count resumes from its held value on release.
- mode_load with mode_sel=6 → no change. mode_load with mode_sel=3 on the same cycle as a tick → mode_cur=3, s=0, no cycle_done.
- LED_PWM_EN, PWM_BITS=4, brightness=4, mode 4 on-phase → each LED is high for 4 of every 16 cycles. brightness=15 → constantly high. brightness=0 → constantly low.

Source files
------------

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: multi-mode LED pattern generator with speed prescale, pause and auto-cycling.
// Define LED_PWM_EN to add the brightness port and PWM gating of the LED outputs.
module led_pattern_engine #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int STEP_HZ  = 4,
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                clk_50mhz,
  input  logic                rst_n,
  input  logic [2:0]          mode_sel,
  input  logic                mode_load,
  input  logic                auto_cycle,
  input  logic [1:0]          speed,
  input  logic                pause,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] brightness,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic [2:0]          mode_cur,
  output logic                step_tick,
  output logic                cycle_done
);
  localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
  localparam int DW = $clog2(STEP_DIV * 8);
  localparam int SW = NUM_LEDS > 5 ? NUM_LEDS : 5;
  if (NUM_LEDS < 2 || NUM_LEDS > 16 || PWM_BITS < 1) begin : g_bad
    $error("led_pattern_engine: illegal parameters");
  end
  logic [DW-1:0] div, lim;
  logic [SW-1:0] s, last, pos;
  logic [NUM_LEDS-1:0] pat, alt, ones;
  logic wrap, load_ok, done_now, gate;
  assign ones = '1;
  assign lim = DW'((STEP_DIV << speed) - 1);
  assign wrap = !pause && div >= lim;
  assign load_ok = mode_load && mode_sel <= 3'd4;
  assign last = mode_cur == 3'd0 ? SW'((1 << NUM_LEDS) - 1) :
                mode_cur == 3'd1 ? SW'(2 * NUM_LEDS - 3) :
                mode_cur == 3'd2 ? SW'(2 * NUM_LEDS - 1) : SW'(7);
  assign done_now = wrap && s == last;
  assign pos = s < SW'(NUM_LEDS) ? s : SW'(2 * NUM_LEDS - 2) - s;
  always_comb begin
    alt = '0;
    for (int i = 0; i < NUM_LEDS; i++) alt[i] = s[0] ^ ~i[0];
  end
  assign pat = mode_cur == 3'd0 ? s[NUM_LEDS-1:0] :
               mode_cur == 3'd1 ? NUM_LEDS'(1) << pos :
               mode_cur == 3'd2 ? (s <= SW'(NUM_LEDS) ? ~(ones << s) : ones << (s - SW'(NUM_LEDS))) :
               mode_cur == 3'd3 ? alt : {NUM_LEDS{s[0]}};
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pc;
  assign gate = pc < brightness || &brightness;
  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= pc + 1'b1;
`else
  assign gate = 1'b1;
`endif
  // a valid load overrides a coincident divider wrap entirely
  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) begin
      led <= '0;
      mode_cur <= '0;
      s <= '0;
      div <= '0;
      step_tick <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      led <= pat & {NUM_LEDS{gate}};
      step_tick <= wrap && !load_ok;
      cycle_done <= done_now && !load_ok;
      if (load_ok) begin
        mode_cur <= mode_sel;
        s <= '0;
        div <= '0;
      end else if (wrap) begin
        div <= '0;
        s <= done_now ? '0 : s + 1'b1;
        if (done_now && auto_cycle) mode_cur <= mode_cur == 3'd4 ? 3'd0 : mode_cur + 3'd1;
      end else if (!pause) div <= div + 1'b1;
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed checks of pattern modes, divider timing, pause, loads and reset.
module tb_led_pattern_engine;
  logic clk_50mhz = 1'b0, rst_n = 1'b0;
  logic [2:0] mode_sel = '0;
  logic mode_load = 1'b0, auto_cycle = 1'b0, pause = 1'b0;
  logic [1:0] speed = '0;
  logic [3:0] led;
  logic [2:0] mode_cur;
  logic step_tick, cycle_done;
`ifdef LED_PWM_EN
  logic [3:0] brightness = 4'hF;
`endif
  int n_chk = 0, n_bad = 0;
  led_pattern_engine #(.CLK_FREQ(40), .STEP_HZ(4), .NUM_LEDS(4), .PWM_BITS(4)) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n(rst_n),
    .mode_sel(mode_sel),
    .mode_load(mode_load),
    .auto_cycle(auto_cycle),
    .speed(speed),
    .pause(pause),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .led(led),
    .mode_cur(mode_cur),
    .step_tick(step_tick),
    .cycle_done(cycle_done)
  );
  always #5 clk_50mhz = ~clk_50mhz;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!step_tick && n < budget);
    if (!step_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_step(input string tag, input logic [3:0] exp_led, input logic exp_done, input int exp_gap);
    int n;
    wait_tick(200, n);
    chk({tag, "_gap"}, n, exp_gap);
    chk({tag, "_done"}, {31'd0, cycle_done}, {31'd0, exp_done});
    step();
    chk({tag, "_led"}, {28'd0, led}, {28'd0, exp_led});
  endtask
  task automatic load_mode(input logic [2:0] sel, input logic [3:0] exp_led);
    mode_sel = sel;
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    chk("load_mode", {29'd0, mode_cur}, {29'd0, sel});
    step();
    chk("load_led", {28'd0, led}, {28'd0, exp_led});
  endtask
  logic [3:0] m1_tab [6] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] m2_tab [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h5};
  logic [3:0] m3_tab [8] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h0};
  initial begin
    int ticks, changes, hi;
    logic [3:0] l0;
    repeat (3) step();
    chk("rst_led", {28'd0, led}, 32'd0);
    chk("rst_mode", {29'd0, mode_cur}, 32'd0);
    chk("rst_tick", {31'd0, step_tick}, 32'd0);
    chk("rst_done", {31'd0, cycle_done}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("m0_led0", {28'd0, led}, 32'd0);
    for (int i = 1; i <= 16; i++) do_step("m0", 4'(i), i == 16, 9);
    load_mode(3'd1, 4'h1);
    for (int i = 0; i < 12; i++) do_step("m1", m1_tab[i % 6], (i % 6) == 5, 9);
    chk("m1_mode", {29'd0, mode_cur}, 32'd1);
    auto_cycle = 1'b1;
    load_mode(3'd2, 4'h0);
    for (int i = 0; i < 8; i++) do_step("m2", m2_tab[i], i == 7, 9);
    chk("m2_next", {29'd0, mode_cur}, 32'd3);
    for (int i = 0; i < 8; i++) do_step("m3", m3_tab[i], i == 7, 9);
    chk("m3_next", {29'd0, mode_cur}, 32'd4);
    auto_cycle = 1'b0;
    speed = 2'd2;
    do_step("spd2a", 4'hF, 1'b0, 39);
    do_step("spd2b", 4'h0, 1'b0, 39);
    repeat (20) step();
    pause = 1'b1;
    l0 = led;
    ticks = 0;
    changes = 0;
    repeat (100) begin
      step();
      if (step_tick) ticks++;
      if (led != l0) changes++;
    end
    chk("pause_ticks", ticks, 0);
    chk("pause_led", changes, 0);
    pause = 1'b0;
    do_step("resume", 4'hF, 1'b0, 19);
    repeat (15) step();
    speed = 2'd0;
    do_step("spd_drop", 4'h0, 1'b0, 1);
    mode_sel = 3'd6;
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    chk("bad_load_mode", {29'd0, mode_cur}, 32'd4);
    do_step("bad_load", 4'hF, 1'b0, 8);
    do_step("m4a", 4'h0, 1'b0, 9);
    do_step("m4b", 4'hF, 1'b0, 9);
    auto_cycle = 1'b1;
    repeat (8) step();
    mode_sel = 3'd3;
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    auto_cycle = 1'b0;
    chk("ld_tick_tick", {31'd0, step_tick}, 32'd0);
    chk("ld_tick_done", {31'd0, cycle_done}, 32'd0);
    chk("ld_tick_mode", {29'd0, mode_cur}, 32'd3);
    step();
    chk("ld_tick_led", {28'd0, led}, 32'h5);
    do_step("after_ld", 4'hA, 1'b0, 9);
    @(posedge clk_50mhz);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", {28'd0, led}, 32'd0);
    chk("arst_mode", {29'd0, mode_cur}, 32'd0);
`ifdef LED_PWM_EN
    @(posedge clk_50mhz);
    #1 rst_n = 1'b1;
    load_mode(3'd4, 4'h0);
    do_step("pwm_on", 4'hF, 1'b0, 9);
    pause = 1'b1;
    for (int b = 0; b < 3; b++) begin
      brightness = b == 0 ? 4'd4 : b == 1 ? 4'd15 : 4'd0;
      repeat (3) step();
      hi = 0;
      changes = 0;
      repeat (16) begin
        step();
        if (led == 4'hF) hi++;
        else if (led != 4'h0) changes++;
      end
      chk("pwm_hi", hi, b == 0 ? 4 : b == 1 ? 16 : 0);
      chk("pwm_mixed", changes, 0);
    end
    pause = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
